// File: rtl/calc_pkg.sv
// Shared definitions for the hex calculator ALU operators.
package calc_pkg;

  localparam int unsigned WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } alu_state_t;

  // Quotient reported when the divisor is zero.
  localparam logic [WIDTH_DEFAULT-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/unsigned_div_step.sv
// One combinational restoring-division step: shift in the next dividend bit and
// subtract the divisor if it fits.
module unsigned_div_step #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] work_r,
  input  logic [WIDTH-1:0] work_q,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] next_r_c,
  output logic [WIDTH-1:0] next_q_c
);

  logic [WIDTH:0] trial;

  always_comb begin
    trial = {work_r, work_q[WIDTH-1]} - {1'b0, d};
    if (!trial[WIDTH]) begin
      next_r_c = trial[WIDTH-1:0];
      next_q_c = {work_q[WIDTH-2:0], 1'b1};
    end else begin
      next_r_c = {work_r[WIDTH-2:0], work_q[WIDTH-1]};
      next_q_c = {work_q[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/unsigned_div.sv
// Sequential unsigned restoring divider, one quotient bit per clock, with the
// parser_done / alu_done handshake shared by the other ALU operators.
module unsigned_div
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] D,
  input  logic             parser_done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero,
  output logic             busy,
  output logic             alu_done
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [1:0] ST_IDLE = 2'(IDLE);
  localparam logic [1:0] ST_CALC = 2'(CALC);
  localparam logic [1:0] ST_DONE = 2'(DONE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic             parser_done_d;
  logic             armed;
  logic             start;
  logic             last_iter;
  logic [WIDTH-1:0] d_reg;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] work_r;
  logic [WIDTH-1:0] next_q;
  logic [WIDTH-1:0] next_r;
  logic [CNT_W-1:0] cnt;

  // armed stays low after reset until parser_done is seen low, so a level held
  // across reset is not mistaken for a fresh request.
  assign start     = parser_done & ~parser_done_d & armed;
  assign last_iter = (state == ST_CALC) && (cnt == CNT_LAST);

  unsigned_div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .work_r   (work_r),
    .work_q   (work_q),
    .d        (d_reg),
    .next_r_c (next_r),
    .next_q_c (next_q)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = (D == '0) ? ST_DONE : ST_CALC;
    end else if (last_iter) begin
      state_next = ST_DONE;
    end
  end

  // Datapath and registered outputs; results publish only on entry to DONE.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      parser_done_d <= 1'b0;
      armed         <= 1'b0;
      d_reg         <= '0;
      work_q        <= '0;
      work_r        <= '0;
      cnt           <= '0;
      quotient      <= '0;
      remainder     <= '0;
      div_zero      <= 1'b0;
      busy          <= 1'b0;
      alu_done      <= 1'b0;
    end else begin
      parser_done_d <= parser_done;
      armed         <= armed | ~parser_done;
      busy          <= (state_next == ST_CALC);
      alu_done      <= (state_next == ST_DONE);
      if (start) begin
        d_reg  <= D;
        work_q <= N;
        work_r <= '0;
        cnt    <= '0;
        if (D == '0) begin
          quotient  <= '1;
          remainder <= N;
          div_zero  <= 1'b1;
        end
      end else if (state == ST_CALC) begin
        work_q <= next_q;
        work_r <= next_r;
        cnt    <= cnt + CNT_W'(1);
        if (last_iter) begin
          quotient  <= next_q;
          remainder <= next_r;
          div_zero  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_unsigned_div.sv
// Bench for unsigned_div: arithmetic reference model checked every cycle, plus
// directed literal checks for the documented scenarios.
module tb_unsigned_div;

  localparam int unsigned W = 16;
  localparam int LATENCY = 16;

  logic         clk;
  logic         n_rst;
  logic [W-1:0] N;
  logic [W-1:0] D;
  logic         parser_done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;
  logic         busy;
  logic         alu_done;

  int n_tests = 0;
  int n_fail  = 0;

  unsigned_div #(.WIDTH(W)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .N           (N),
    .D           (D),
    .parser_done (parser_done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_zero    (div_zero),
    .busy        (busy),
    .alu_done    (alu_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a request is a rising parser_done seen after parser_done
  // has been low since reset; the answer is plain N/D and N%D after 16 clocks.
  logic [W-1:0] m_q, m_r, pend_q, pend_r;
  logic         m_dz, m_busy, m_done;
  logic         pd_prev, seen_low;
  int           remaining;

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      m_q = '0; m_r = '0; m_dz = 1'b0; m_busy = 1'b0; m_done = 1'b0;
      pend_q = '0; pend_r = '0; pd_prev = 1'b0; seen_low = 1'b0; remaining = 0;
    end else begin
      if (parser_done && !pd_prev && seen_low) begin
        if (D == 0) begin
          m_q = '1; m_r = N; m_dz = 1'b1;
          m_done = 1'b1; m_busy = 1'b0; remaining = 0;
        end else begin
          pend_q = N / D; pend_r = N % D;
          remaining = LATENCY; m_busy = 1'b1; m_done = 1'b0;
        end
      end else if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_q = pend_q; m_r = pend_r; m_dz = 1'b0;
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
      pd_prev = parser_done;
      if (!parser_done) seen_low = 1'b1;
    end
  end

  always @(negedge clk) begin
    check("quotient",  32'(quotient),  32'(m_q));
    check("remainder", 32'(remainder), 32'(m_r));
    check("div_zero",  32'(div_zero),  32'(m_dz));
    check("busy",      32'(busy),      32'(m_busy));
    check("alu_done",  32'(alu_done),  32'(m_done));
    check("busy_and_done_exclusive", 32'(busy & alu_done), 32'd0);
  end

  // Leaves the caller 1ns after the start edge E.
  task automatic start_op(input logic [W-1:0] n, input logic [W-1:0] d, input bit hold);
    @(posedge clk); #1;
    N = n; D = d; parser_done = 1'b1;
    @(posedge clk); #1;
    if (!hold) parser_done = 1'b0;
    N = 16'($urandom); D = 16'($urandom);
  endtask

  task automatic expect_result(input string name, input logic [W-1:0] q, input logic [W-1:0] r);
    repeat (LATENCY - 1) @(posedge clk);
    #1;
    check({name, "_not_early"}, 32'(alu_done), 32'd0);
    @(posedge clk); #1;
    check({name, "_done"}, 32'(alu_done), 32'd1);
    check({name, "_q"},    32'(quotient), 32'(q));
    check({name, "_r"},    32'(remainder), 32'(r));
    check({name, "_dz"},   32'(div_zero), 32'd0);
  endtask

  initial begin
    n_rst = 1'b0; parser_done = 1'b0; N = '0; D = '0;
    #1;
    check("rst_q", 32'(quotient), 32'd0);
    check("rst_r", 32'(remainder), 32'd0);
    check("rst_busy_done_dz", 32'({busy, alu_done, div_zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;

    start_op(16'd100, 16'd7, 1'b0);
    expect_result("div_100_7", 16'd14, 16'd2);
    start_op(16'hFFFF, 16'd1, 1'b0);
    expect_result("div_ffff_1", 16'hFFFF, 16'd0);
    start_op(16'hFFFF, 16'hFFFF, 1'b0);
    expect_result("div_ffff_ffff", 16'd1, 16'd0);
    start_op(16'd3, 16'd10, 1'b0);
    expect_result("div_3_10", 16'd0, 16'd3);

    start_op(16'd5, 16'd0, 1'b0);
    check("dz_done", 32'(alu_done), 32'd1);
    check("dz_flag", 32'(div_zero), 32'd1);
    check("dz_q",    32'(quotient), 32'hFFFF);
    check("dz_r",    32'(remainder), 32'd5);
    check("dz_busy", 32'(busy), 32'd0);

    // Restart mid-calculation; model checks the old result is held throughout.
    start_op(16'd100, 16'd7, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    start_op(16'd50, 16'd6, 1'b0);
    check("abort_hold_q", 32'(quotient), 32'hFFFF);
    expect_result("abort_50_6", 16'd8, 16'd2);

    // Reset during CALC with parser_done held high across it.
    start_op(16'd1000, 16'd3, 1'b1);
    repeat (5) @(posedge clk);
    #1 n_rst = 1'b0;
    #1;
    check("midrst_q", 32'(quotient), 32'd0);
    check("midrst_r", 32'(remainder), 32'd0);
    check("midrst_flags", 32'({busy, alu_done, div_zero}), 32'd0);
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("held_no_start_busy", 32'(busy), 32'd0);
    check("held_no_start_done", 32'(alu_done), 32'd0);
    parser_done = 1'b0;
    start_op(16'd50, 16'd6, 1'b0);
    expect_result("after_rst_50_6", 16'd8, 16'd2);

    // Random requests: varied hold lengths, gaps that abort, finish, or restart from DONE.
    for (int i = 0; i < 250; i++) begin
      int hi;
      int lo;
      hi = int'($urandom_range(1, 3));
      lo = int'($urandom_range(1, 22));
      @(posedge clk); #1;
      N = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       D = '0;
        1:       D = 16'($urandom_range(1, 20));
        2:       D = 16'($urandom_range(1, 400));
        default: D = 16'($urandom);
      endcase
      parser_done = 1'b1;
      for (int k = 1; k < hi; k++) begin
        @(posedge clk); #1;
        N = 16'($urandom); D = 16'($urandom);
      end
      @(posedge clk); #1;
      parser_done = 1'b0;
      for (int k = 0; k < lo; k++) begin
        @(posedge clk); #1;
        N = 16'($urandom); D = 16'($urandom);
      end
    end

    repeat (20) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
